// File: rtl/fp_pkg.sv
// Shared definitions for the sample front-end and the floating-point converter.
// It holds the sample width and the deserializer state encoding.
package fp_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

endpackage

// File: rtl/sample_hold_reg.sv
// One-entry holding register between the deserializer and the converter.
// A new word is taken when the register is empty or is draining in the same cycle.
module sample_hold_reg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             drop
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // While valid=1 and ready=0, dout and valid hold. ready with valid=0 does nothing.
    logic accept;

    assign accept = load && (!valid || ready);
    assign drop   = load && valid && !ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (accept) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_sample_deserializer.sv
// Assembles MSB-first serial samples into WIDTH-bit words for the converter.
// Partial frames interrupted by a new start are discarded and flagged.
module serial_sample_deserializer
    import fp_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_en,
    input  logic             s_start,
    input  logic             s_data,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    input  logic             d_ready,
    input  logic             clr_flags,
    output logic             overrun,
    output logic             frame_err,
    output deser_state_t     dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    deser_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             restart;
    logic             drop;

    assign word      = {sr[WIDTH-2:0], s_data};
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        complete  = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (s_en && s_start) begin
                    sr_nxt    = {{(WIDTH-1){1'b0}}, s_data};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (s_en) begin
                    if (s_start) begin
                        // A start before the word is complete always wins over completion.
                        restart = 1'b1;
                        sr_nxt  = {{(WIDTH-1){1'b0}}, s_data};
                        cnt_nxt = CNT_W'(1);
                    end else if (cnt == CNT_LAST) begin
                        complete  = 1'b1;
                        sr_nxt    = word;
                        cnt_nxt   = CNT_FULL;
                        state_nxt = IDLE;
                    end else begin
                        sr_nxt  = word;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    sample_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (complete),
        .din   (word),
        .ready (d_ready),
        .dout  (d_out),
        .valid (d_valid),
        .drop  (drop)
    );

    // Set events take priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= drop    || (overrun   && !clr_flags);
            frame_err <= restart || (frame_err && !clr_flags);
        end
    end

endmodule
